// File: rtl/nic_rr_arbiter.sv
// Round-robin arbiter: four NIC senders share one registered output channel, 1-cycle latency.
// Drain and refill can share a cycle, so out_ri held high gives one packet per cycle; stalls hold everything.
module nic_rr_arbiter #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [0:3]            req_si,
  input  logic [0:DATA_WIDTH-1] req_di0,
  input  logic [0:DATA_WIDTH-1] req_di1,
  input  logic [0:DATA_WIDTH-1] req_di2,
  input  logic [0:DATA_WIDTH-1] req_di3,
  output logic [0:3]            req_ro,
  output logic                  out_so,
  output logic [0:DATA_WIDTH-1] out_do,
  input  logic                  out_ri,
  output logic [1:0]            grant_id,
  output logic [15:0]           pkt_cnt
);

  logic                  out_so_q, out_so_d;
  logic [0:DATA_WIDTH-1] out_do_q, out_do_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [1:0]            win;
  logic                  win_vld;
  logic                  can_accept;
  logic                  xfer;
  logic [0:DATA_WIDTH-1] win_dat;

  // Scan from lowest to highest priority so the nearest requester to ptr wins.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req_si[ptr_q + 2'(k)]) begin
        win     = ptr_q + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  assign can_accept = !out_so_q || out_ri;
  assign xfer       = win_vld && can_accept && RESET;

  always_comb begin
    req_ro = '0;
    if (xfer) req_ro[win] = 1'b1;
  end

  always_comb begin
    win_dat = req_di0;
    case (win)
      2'd1:    win_dat = req_di1;
      2'd2:    win_dat = req_di2;
      2'd3:    win_dat = req_di3;
      default: win_dat = req_di0;
    endcase
  end

  always_comb begin
    out_so_d = out_so_q;
    out_do_d = out_do_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    if (xfer) begin
      out_so_d = 1'b1;
      out_do_d = win_dat;
      grant_d  = win;
      ptr_d    = win + 2'd1;
      cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else if (out_so_q && out_ri) begin
      out_so_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      out_so_q <= 1'b0;
      out_do_q <= '0;
      grant_q  <= 2'd0;
      ptr_q    <= 2'd0;
      cnt_q    <= 16'd0;
    end else begin
      out_so_q <= out_so_d;
      out_do_q <= out_do_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_so   = out_so_q;
  assign out_do   = out_do_q;
  assign grant_id = grant_q;
  assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_nic_rr_arbiter.sv
// Bench for nic_rr_arbiter: directed scenarios plus constrained-random traffic,
// checked against a queue-based round-robin reference model.
module tb_nic_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [0:3]  req_si;
  logic [0:63] req_di0, req_di1, req_di2, req_di3;
  logic [0:3]  req_ro;
  logic        out_so;
  logic [0:63] out_do;
  logic        out_ri;
  logic [1:0]  grant_id;
  logic [15:0] pkt_cnt;

  nic_rr_arbiter #(.DATA_WIDTH(64)) dut (
    .CLK(CLK), .RESET(RESET), .req_si(req_si),
    .req_di0(req_di0), .req_di1(req_di1), .req_di2(req_di2), .req_di3(req_di3),
    .req_ro(req_ro), .out_so(out_so), .out_do(out_do), .out_ri(out_ri),
    .grant_id(grant_id), .pkt_cnt(pkt_cnt)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  gid;
  } exp_t;

  exp_t        sb_q[$];
  int          gid_log[$];
  int          n_checks = 0;
  int          n_errs   = 0;

  logic [63:0] di[4];
  int          m_ptr, m_cnt, m_gid;
  bit          m_full, m_known;
  logic [63:0] m_data;
  logic [0:3]  m_ro;
  int          waits[4];
  logic [0:3]  cur_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, compare, then advance the model.
  task automatic step(input logic rst, input logic [0:3] req, input logic ori);
    logic [0:3] exp_ro;
    int         w;
    bit         found;
    exp_t       e;
    @(posedge CLK);
    #1;
    RESET   = rst;
    req_si  = req;
    out_ri  = ori;
    req_di0 = di[0];
    req_di1 = di[1];
    req_di2 = di[2];
    req_di3 = di[3];
    #1;
    exp_ro = '0;
    w      = 0;
    found  = 0;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && req[(m_ptr + k) % 4]) begin
          w     = (m_ptr + k) % 4;
          found = 1;
        end
      end
    end
    if (found && (!m_full || ori)) exp_ro[w] = 1'b1;

    chk("req_ro", req_ro, exp_ro);
    if (m_known) begin
      chk("out_so", out_so, m_full);
      chk("pkt_cnt", pkt_cnt, m_cnt);
      chk("out_do", out_do, m_data);
      chk("grant_id", grant_id, m_gid);
    end

    // Fairness measured on the DUT's own grants: a held request waits at most 3 others.
    for (int n = 0; n < 4; n++) begin
      if (!rst || !req[n]) waits[n] = 0;
      else if (req_ro[n]) begin
        chk("fairness", (waits[n] <= 3), 1);
        waits[n] = 0;
      end else if (req_ro != 4'b0000) waits[n]++;
    end

    if (!rst) begin
      m_full = 0; m_ptr = 0; m_cnt = 0; m_data = '0; m_gid = 0; m_known = 1;
      sb_q.delete();
    end else if (exp_ro != 4'b0000) begin
      e.data = di[w];
      e.gid  = 2'(w);
      sb_q.push_back(e);
      m_data = di[w];
      m_gid  = w;
      m_full = 1;
      m_ptr  = (w + 1) % 4;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_full && ori) begin
      m_full = 0;
    end
    m_ro = exp_ro;
  endtask

  // Monitor: every downstream handshake must match the oldest predicted packet.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && out_so === 1'b1 && out_ri === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL sb_unexpected: got packet %h gid %0d expected none", out_do, grant_id);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", out_do, e.data);
          chk("sb_gid", grant_id, e.gid);
          gid_log.push_back(int'(grant_id));
        end
      end
    end
  end

  initial begin
    RESET = 1'b0; req_si = '0; out_ri = 1'b0;
    req_di0 = '0; req_di1 = '0; req_di2 = '0; req_di3 = '0;
    m_known = 0; m_full = 0; m_ptr = 0; m_cnt = 0; m_gid = 0; m_data = '0; m_ro = '0;
    cur_req = '0;
    for (int n = 0; n < 4; n++) begin
      di[n]    = 64'(n);
      waits[n] = 0;
    end

    // Reset with all requesters active, then full rotation.
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    chk("rst_ro", req_ro, 4'b0000);
    gid_log.delete();
    step(1'b1, 4'b1111, 1'b1);
    chk("first_grant", req_ro, 4'b1000);
    repeat (7) step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("rot_cnt", pkt_cnt, 16'd8);
    step(1'b1, 4'b0000, 1'b0);
    chk("rot_len", gid_log.size(), 8);
    for (int i = 0; i < gid_log.size() && i < 8; i++) chk("rot_gid", gid_log[i], i % 4);

    // Pointer skip and wrap: ptr=3 after node 2, nodes 0 and 2 requesting.
    for (int n = 0; n < 4; n++) di[n] = {$urandom, $urandom};
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b1000, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0010, 1'b1);
    step(1'b1, 4'b1010, 1'b1);
    chk("wrap_first", req_ro, 4'b1000);
    step(1'b1, 4'b0010, 1'b1);
    chk("wrap_second", req_ro, 4'b0010);

    // Backpressure while holding node 1's packet, then same-cycle refill.
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    repeat (5) begin
      step(1'b1, 4'b1111, 1'b0);
      chk("bp_ro", req_ro, 4'b0000);
      chk("bp_gid", grant_id, 2'd1);
      chk("bp_data", out_do, di[1]);
    end
    step(1'b1, 4'b1111, 1'b1);
    chk("bp_refill", req_ro, 4'b0010);
    step(1'b1, 4'b0000, 1'b1);
    chk("bp_out_so", out_so, 1'b1);
    chk("bp_gid2", grant_id, 2'd2);

    // Drain to empty, ptr retained at 0, no-bubble accept from node 0.
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0001, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("drain_so_hold", out_so, 1'b1);
    step(1'b1, 4'b1000, 1'b1);
    chk("drain_so", out_so, 1'b0);
    chk("drain_ro", req_ro, 4'b1000);

    // Reset during a stall discards the held packet.
    step(1'b0, 4'b0000, 1'b1);
    step(1'b1, 4'b0100, 1'b1);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    chk("mid_rst_ro", req_ro, 4'b0000);
    step(1'b1, 4'b0000, 1'b1);
    chk("mid_rst_so", out_so, 1'b0);
    step(1'b1, 4'b0000, 1'b1);

    // Random traffic: pending requests and their data stay put until accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (!(cur_req[n] && !m_ro[n])) begin
          cur_req[n] = ($urandom_range(0, 2) != 0);
          di[n]      = {$urandom, $urandom};
        end
      end
      step(($urandom_range(0, 99) != 0), cur_req, ($urandom_range(0, 3) != 0));
    end

    // Counter saturation.
    step(1'b0, 4'b0000, 1'b1);
    repeat (65540) step(1'b1, 4'b1111, 1'b1);
    chk("sat_cnt", pkt_cnt, 16'hFFFF);
    step(1'b1, 4'b0000, 1'b1);
    step(1'b1, 4'b0000, 1'b1);
    chk("sat_hold", pkt_cnt, 16'hFFFF);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/nic_rr_arbiter.md
# nic_rr_arbiter

Round-robin arbiter that shares one 64-bit outbound packet channel among the four node NICs of the 4-core CMP. Each NIC presents a packet with a valid/ready handshake. The arbiter picks one requester per cycle, captures its packet into a single output register, and presents it downstream with its own valid/ready handshake. It sits between the per-node NIC output channels and the shared inter-node link, and it provides full throughput with fair, starvation-free rotation.

## Interface

- DATA_WIDTH, 64, packet width; bit 0 is the MSB, matching the [0:63] ordering used across the design
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-low reset: sampled on posedge CLK, state cleared when RESET==0
- req_si  in  [0:3]  send-valid, one bit per node NIC (bit n = node n)
- req_di0, req_di1, req_di2, req_di3  in  [0:DATA_WIDTH-1]  packet from node n; must be stable while req_si[n]=1 and not yet accepted
- req_ro  out  [0:3]  ready to node n; at most one bit set (one-hot or zero)
- out_so  out  1  output valid
- out_do  out  [0:DATA_WIDTH-1]  output packet (registered)
- out_ri  in  1  downstream ready
- grant_id  out  2  index of the node whose packet is in out_do (registered)
- pkt_cnt  out  16  total packets accepted since reset; saturates at 16'hFFFF

## Operation

- State:
  - Output register: out_so, out_do, grant_id.
  - Round-robin pointer ptr[1:0]: the highest-priority node for the current cycle.
  - pkt_cnt.
- Output register is EMPTY when out_so=0 and FULL when out_so=1.
- can_accept = (out_so==0) || (out_ri==1). A drain and a refill may happen in the same cycle.
- Winner w: the first n with req_si[n]=1, searching in order ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- req_ro[w] = can_accept && (RESET==1) && (some req_si set). All other req_ro bits are 0. req_ro is combinational from req_si, ptr, out_so, out_ri and RESET.
- Transfer from node w occurs when req_si[w] && req_ro[w]. On the next edge:
  - out_do <= req_di{w}
  - grant_id <= w
  - out_so <= 1
  - ptr <= (w+1) mod 4, wrapping 3 to 0
  - pkt_cnt <= pkt_cnt+1, unless already at FFFF
- Drain with no transfer (out_so && out_ri and no winner): on the next edge out_so <= 0. out_do and grant_id hold their last values.
- Stall (out_so && !out_ri): out_so, out_do, grant_id and ptr all hold. req_ro is all zero.
- ptr advances only on a transfer. Idle cycles and stalls do not rotate priority.
- Fairness: a node with req_si held high is granted within 4 transfers.
- Reset (RESET==0 at a posedge), whatever is in flight:
  - out_so=0, out_do=0, grant_id=0, ptr=0, pkt_cnt=0.
  - req_ro=0 while RESET==0.
  - A packet held in the output register is discarded.
  - A transfer combinationally offered in the reset cycle does not occur.

## Timing

- Latency: 1 cycle. A packet accepted at edge k has out_so=1 with the packet on out_do after edge k.
- Throughput: 1 packet/cycle when out_ri is held high and requests are present.
- Downstream handshake: the packet leaves at the edge where out_so && out_ri.
  - Once out_so=1, out_do and grant_id are stable until that edge.
  - out_so never drops without a handshake, except by reset.
- No combinational path from req_di* to any output. The paths req_si -> req_ro and out_ri -> req_ro are combinational.
- pkt_cnt updates at the same edge as the transfer it counts.

## Test plan

- Reset: drive RESET=0 for 2 cycles with req_si=4'b1111 -> req_ro=0, out_so=0, out_do=0, grant_id=0, pkt_cnt=0. After release, the first grant goes to node 0.
- Full rotation: req_si=4'b1111, distinct data (req_di n = 64'h0000_0000_0000_000n), out_ri=1 for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, out_so continuously 1, pkt_cnt=8.
- Pointer skip and wrap: ptr=3 (node 2 was just granted), req_si=4'b1010 (nodes 0 and 2) -> node 0 granted first (wrap 3 to 0 with node 3 idle), then node 2.
- Backpressure: out_so=1 with a packet from node 1, out_ri=0 for 5 cycles, req_si=4'b1111 -> req_ro=0 and out_do/grant_id stable throughout. On raising out_ri, the same-cycle refill grants node 2 and out_so stays 1.
- Drain to empty: a single packet from node 3, then req_si=0 with out_ri=1 -> out_so falls 1 cycle after the handshake and ptr=0 is retained. A subsequent request from node 0 is accepted without a bubble: req_ro[0]=1 in the same cycle.
- Mid-operation reset and saturation:
  - Assert RESET=0 while out_so=1 and out_ri=0 -> the register is cleared next edge and the held packet is never presented.
  - Preload pkt_cnt to FFFE via 2 transfers past the forced value, or run 65537 transfers -> pkt_cnt sticks at FFFF.
